regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, register data width.
REQ-002 SHALL have parameter DEPTH, default 32, register count (power of two, >=2); AW = log2(DEPTH).
REQ-003 SHALL have parameter NUM_RD, default 2, number of read ports.
REQ-004 SHALL have parameter NUM_WR, default 2, number of write ports.
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-007 SHALL have port rd_addr  input  NUM_RD*AW  read addresses, port i at bits [i*AW +: AW].
REQ-008 SHALL have port rd_data  output  NUM_RD*XLEN  read data, combinational from rd_addr.
REQ-009 SHALL have port rd_busy  output  NUM_RD  scoreboard busy bit of each read address.
REQ-010 SHALL have port wr_en  input  NUM_WR  per-port write enable.
REQ-011 SHALL have port wr_addr  input  NUM_WR*AW  write addresses.
REQ-012 SHALL have port wr_data  input  NUM_WR*XLEN  write data.
REQ-013 SHALL have port sb_set_en  input  1  mark destination pending (instruction issue).
REQ-014 SHALL have port sb_set_addr  input  AW  destination to mark pending.
REQ-015 SHALL have port init_done  output  1  high once zero-initialisation complete.

Function
REQ-016 Entry 0 SHALL read as zero always; writes and scoreboard sets to address 0 SHALL be ignored; rd_busy for address 0 SHALL be 0.
REQ-017 Write SHALL commit at the rising edge where wr_en[j]=1, addr!=0, init_done=1.
REQ-018 Multiple write ports to same address in one cycle: highest port index SHALL win.
REQ-019 Init FSM states INIT, RUN; INIT clears one entry per cycle, counter 1..DEPTH-1, then RUN; init_done=1 only in RUN; INIT lasts DEPTH-1 cycles after reset release.
REQ-020 During INIT, wr_en and sb_set_en SHALL be ignored, rd_data SHALL read 0, rd_busy SHALL be 0.
REQ-021 Scoreboard: busy[a] SHALL set at edge with sb_set_en and sb_set_addr=a; SHALL clear at edge with committed write to a.
REQ-022 Set and clear of same address in same cycle: set SHALL win (busy stays 1, new producer).
REQ-023 rd_busy[i] SHALL reflect registered busy state only (no same-cycle set/clear lookahead).
REQ-024 Read ports SHALL be independent; any addresses, including all equal, SHALL be legal.

Reset
REQ-025 On rst low, asynchronously: FSM=INIT, counter=1, all busy bits=0, init_done=0, entry 0=0.
REQ-026 Reset asserted mid-INIT or mid-RUN SHALL restart the full init sequence; storage beyond entry 0 is undefined until cleared.

Configuration
REQ-027 Macro REGFILE_BYPASS_EN defined: read port SHALL return same-cycle committed wr_data on address match (highest matching write port), excluding address 0 and INIT.
REQ-028 Macro undefined: read ports SHALL return stored value only; write visible the cycle after commit.

Structure
REQ-029 Shared package regfile_pkg SHALL hold the FSM state encoding (ST_INIT, ST_RUN) and default XLEN/DEPTH constants.
REQ-030 Scoreboard SHALL be a sub-module regfile_scoreboard (busy vector, set/clear, priority rule); storage, init FSM, bypass stay in regfile_mp.

Verification
REQ-031 Reset released, DEPTH=32 -> init_done low 31 cycles then high; all 31 entries read 0; write during INIT has no effect.
REQ-032 Write x5=0xDEADBEEF via port 0 -> next cycle rd_data port 1 for x5 = 0xDEADBEEF; with REGFILE_BYPASS_EN, same cycle.
REQ-033 Ports 0 and 1 both write x7 (0x11, 0x22) -> x7 reads 0x22.
REQ-034 Write x0=0xFFFFFFFF and sb_set x0 -> x0 reads 0, rd_busy 0.
REQ-035 sb_set x9 -> rd_busy 1 next cycle; write x9 with sb_set x9 same cycle -> busy stays 1; lone write x9 -> busy 0.
REQ-036 Reset pulsed after x3=0x1234 -> init_done drops, x3 reads 0 after init completes, all busy 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: default sizing
// constants and the encoding of the zero-initialisation state machine.
package regfile_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_DEPTH = 32;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } init_state_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register. An issued instruction
// marks its destination busy, and a committed write clears it again. If both
// happen to the same register in one cycle, the set wins because a newer
// producer has just been issued. Register 0 is never busy.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  logic [AW-1:0]    set_addr,
  input  logic [DEPTH-1:0] clr_mask,
  output logic [DEPTH-1:0] busy
);

  logic [DEPTH-1:0] busy_next;

  // Clear committed destinations first, then apply the issue so set wins.
  always_comb begin
    busy_next = busy & ~clr_mask;
    if (set_en && (set_addr != '0)) begin
      busy_next[set_addr] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // Busy vector register, wiped asynchronously on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with zero-initialisation FSM and issue scoreboard.
// Entry 0 is hardwired to zero. After reset the file clears entries
// 1..DEPTH-1, one per cycle, before accepting writes. Define
// REGFILE_BYPASS_EN to forward same-cycle committed write data to the reads.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN   = DEF_XLEN,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic [NUM_RD-1:0]      rd_busy,
  input  logic [NUM_WR-1:0]      wr_en,
  input  logic [NUM_WR*AW-1:0]   wr_addr,
  input  logic [NUM_WR*XLEN-1:0] wr_data,
  input  logic                   sb_set_en,
  input  logic [AW-1:0]          sb_set_addr,
  output logic                   init_done
);

  init_state_t      state, state_next;
  logic [AW-1:0]    init_cnt, init_cnt_next;
  logic             run;
  logic [XLEN-1:0]  mem [DEPTH];
  logic [NUM_WR-1:0] commit;
  logic [DEPTH-1:0] clr_mask;
  logic [DEPTH-1:0] busy;

  // Init FSM state and clear-pointer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_INIT;
      init_cnt <= AW'(1);
    end else begin
      state    <= state_next;
      init_cnt <= init_cnt_next;
    end
  end

  // Walk the clear pointer up to the last entry, then enter RUN for good.
  always_comb begin
    state_next    = state;
    init_cnt_next = init_cnt;
    case (state)
      ST_INIT: begin
        if (init_cnt == AW'(DEPTH - 1)) begin
          state_next = ST_RUN;
        end else begin
          init_cnt_next = init_cnt + AW'(1);
        end
      end
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_INIT;
    endcase
  end

  assign run       = (state == ST_RUN);
  assign init_done = run;

  // A write commits only in RUN and never to entry 0; collect the clear mask.
  always_comb begin
    commit   = '0;
    clr_mask = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      commit[j] = run && wr_en[j] && (wr_addr[j*AW +: AW] != '0);
      if (commit[j]) begin
        clr_mask[wr_addr[j*AW +: AW]] = 1'b1;
      end
    end
  end

  // Storage: clear one entry per cycle during INIT, otherwise apply commits
  // in ascending port order so the highest port wins on a collision.
  always_ff @(posedge clk) begin
    if (!run) begin
      mem[init_cnt] <= '0;
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (commit[j]) begin
          mem[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
        end
      end
    end
  end

  regfile_scoreboard #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (sb_set_en && run),
    .set_addr (sb_set_addr),
    .clr_mask (clr_mask),
    .busy     (busy)
  );

  // Independent read ports: zero for entry 0 and throughout INIT.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (run && (rd_addr[i*AW +: AW] != '0)) begin
        rd_data[i*XLEN +: XLEN] = mem[rd_addr[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
        for (int j = 0; j < NUM_WR; j++) begin
          if (commit[j] && (wr_addr[j*AW +: AW] == rd_addr[i*AW +: AW])) begin
            rd_data[i*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
          end
        end
`else
        rd_data[i*XLEN +: XLEN] = mem[rd_addr[i*AW +: AW]];
`endif
        rd_busy[i] = busy[rd_addr[i*AW +: AW]];
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp with default parameters
// (XLEN=32, DEPTH=32, two read and two write ports).
module tb_regfile_mp;

  localparam int XLEN = 32;
  localparam int AW   = 5;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic            clk;
  logic            rst;
  logic [2*AW-1:0] rd_addr;
  logic [2*XLEN-1:0] rd_data;
  logic [1:0]      rd_busy;
  logic [1:0]      wr_en;
  logic [2*AW-1:0] wr_addr;
  logic [2*XLEN-1:0] wr_data;
  logic            sb_set_en;
  logic [AW-1:0]   sb_set_addr;
  logic            init_done;

  int vectors;
  int miscompares;

  regfile_mp dut (
    .clk         (clk),
    .rst         (rst),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .sb_set_en   (sb_set_en),
    .sb_set_addr (sb_set_addr),
    .init_done   (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive every input for one cycle and let the combinational reads settle.
  task automatic applyStimulus(input logic [1:0] wen,
                               input logic [AW-1:0] wa0, input logic [31:0] wd0,
                               input logic [AW-1:0] wa1, input logic [31:0] wd1,
                               input logic sb_en, input logic [AW-1:0] sb_a,
                               input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
    wr_en       = wen;
    wr_addr     = {wa1, wa0};
    wr_data     = {wd1, wd0};
    sb_set_en   = sb_en;
    sb_set_addr = sb_a;
    rd_addr     = {ra1, ra0};
    #1;
  endtask

  task automatic idle(input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
    applyStimulus(2'b00, '0, '0, '0, '0, 1'b0, '0, ra0, ra1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    idle(5'd0, 5'd5);

    // Reset state
    checkOutput("reset_init_done", {31'd0, init_done}, 32'd0);
    checkOutput("reset_rd1", rd_data[63:32], 32'd0);
    checkOutput("reset_busy", {30'd0, rd_busy}, 32'd0);

    // Release reset; attempt a write and a scoreboard set during INIT
    tick();
    rst = 1'b1;
    applyStimulus(2'b11, 5'd4, 32'hAAAA_AAAA, 5'd4, 32'hBBBB_BBBB, 1'b1, 5'd4, 5'd4, 5'd4);
    for (int k = 0; k < 31; k++) begin
      checkOutput("init_done_low", {31'd0, init_done}, 32'd0);
      checkOutput("init_rd0", rd_data[31:0], 32'd0);
      checkOutput("init_busy", {30'd0, rd_busy}, 32'd0);
      tick();
    end
    idle(5'd4, 5'd4);
    checkOutput("init_done_high", {31'd0, init_done}, 32'd1);
    checkOutput("init_write_ignored", rd_data[31:0], 32'd0);
    checkOutput("init_set_ignored", {30'd0, rd_busy}, 32'd0);

    // Every entry is cleared
    for (int a = 1; a < 32; a++) begin
      idle(AW'(a), AW'(a));
      checkOutput("cleared_rd0", rd_data[31:0], 32'd0);
      checkOutput("cleared_rd1", rd_data[63:32], 32'd0);
    end

    // x5 write through port 0, read on port 1
    applyStimulus(2'b01, 5'd5, 32'hDEAD_BEEF, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd5);
    checkOutput("x5_same_cycle", rd_data[63:32], BYPASS ? 32'hDEAD_BEEF : 32'd0);
    tick();
    idle(5'd5, 5'd5);
    checkOutput("x5_next_cycle", rd_data[63:32], 32'hDEAD_BEEF);

    // Both ports write x7: port 1 wins
    applyStimulus(2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 1'b0, 5'd0, 5'd7, 5'd7);
    checkOutput("x7_same_cycle", rd_data[31:0], BYPASS ? 32'h22 : 32'd0);
    tick();
    idle(5'd7, 5'd7);
    checkOutput("x7_rd0", rd_data[31:0], 32'h22);
    checkOutput("x7_rd1", rd_data[63:32], 32'h22);

    // x0 ignores writes and scoreboard sets
    applyStimulus(2'b01, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0, 5'd0);
    checkOutput("x0_same_cycle", rd_data[31:0], 32'd0);
    tick();
    idle(5'd0, 5'd0);
    checkOutput("x0_data", rd_data[31:0], 32'd0);
    checkOutput("x0_busy", {30'd0, rd_busy}, 32'd0);

    // Scoreboard on x9: set, set+clear, lone clear
    applyStimulus(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd9);
    checkOutput("x9_set_no_lookahead", {31'd0, rd_busy[0]}, 32'd0);
    tick();
    idle(5'd9, 5'd9);
    checkOutput("x9_busy_after_set", {30'd0, rd_busy}, 32'd3);
    applyStimulus(2'b01, 5'd9, 32'h90, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd9);
    tick();
    idle(5'd9, 5'd9);
    checkOutput("x9_set_wins", {31'd0, rd_busy[0]}, 32'd1);
    checkOutput("x9_data_90", rd_data[31:0], 32'h90);
    applyStimulus(2'b10, 5'd0, 32'd0, 5'd9, 32'h99, 1'b0, 5'd0, 5'd9, 5'd9);
    checkOutput("x9_clr_no_lookahead", {31'd0, rd_busy[1]}, 32'd1);
    tick();
    idle(5'd9, 5'd9);
    checkOutput("x9_busy_cleared", {30'd0, rd_busy}, 32'd0);
    checkOutput("x9_data_99", rd_data[63:32], 32'h99);

    // x3 written and x12 marked busy, then reset pulsed
    applyStimulus(2'b01, 5'd3, 32'h1234, 5'd0, 32'd0, 1'b1, 5'd12, 5'd3, 5'd12);
    tick();
    idle(5'd3, 5'd12);
    checkOutput("x3_written", rd_data[31:0], 32'h1234);
    checkOutput("x12_busy", {31'd0, rd_busy[1]}, 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("rst_init_done", {31'd0, init_done}, 32'd0);
    checkOutput("rst_busy", {30'd0, rd_busy}, 32'd0);
    checkOutput("rst_rd0", rd_data[31:0], 32'd0);
    tick();
    rst = 1'b1;
    for (int k = 0; k < 31; k++) begin
      checkOutput("reinit_done_low", {31'd0, init_done}, 32'd0);
      tick();
    end
    checkOutput("reinit_done_high", {31'd0, init_done}, 32'd1);
    checkOutput("reinit_x3", rd_data[31:0], 32'd0);
    checkOutput("reinit_busy", {30'd0, rd_busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
